// File: rtl/sr_ff_pkg.sv
// sr_ff_pkg: shared types and constants for the sr_ff_bank flip-flop bank.
//   mode_t   : run-time channel behaviour (SR, JK, D, T)
//   POL_*    : SR-mode resolution of the forbidden S=R=1 input
package sr_ff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;

endpackage

// File: rtl/sr_ff_cell.sv
// sr_ff_cell: one channel of sr_ff_bank.
// Holds the state bit, its registered complement and a sticky error flag.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   mode      in   2-bit mode select (see sr_ff_pkg::mode_t)
//   en        in   update enable for this channel
//   a, b      in   S/J/D/T and R/K inputs (b ignored in D and T modes)
//   err_clr   in   clears the sticky error flag
//   q, q_bar  out  registered state and registered complement
//   err       out  sticky forbidden-input flag
//   illegal   out  combinational strobe: forbidden input accepted this cycle
module sr_ff_cell
    import sr_ff_pkg::*;
#(
    parameter int ILLEGAL_POL = POL_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       err_clr,
    output logic       q,
    output logic       q_bar,
    output logic       err,
    output logic       illegal
);

    mode_t mode_s;
    logic  q_q, q_d;
    logic  qb_q;
    logic  err_q, err_d;

    assign mode_s = mode_t'(mode);

    always_comb begin
        q_d     = q_q;
        illegal = 1'b0;
        if (en) begin
            unique case (mode_s)
                MODE_SR: begin
                    unique case ({a, b})
                        2'b10:   q_d = 1'b1;
                        2'b01:   q_d = 1'b0;
                        2'b11: begin
                            illegal = 1'b1;
                            if (ILLEGAL_POL == POL_SET)
                                q_d = 1'b1;
                            else if (ILLEGAL_POL == POL_RST)
                                q_d = 1'b0;
                        end
                        default: q_d = q_q;
                    endcase
                end
                MODE_JK: begin
                    unique case ({a, b})
                        2'b10:   q_d = 1'b1;
                        2'b01:   q_d = 1'b0;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                MODE_D:  q_d = a;
                MODE_T:  q_d = a ? ~q_q : q_q;
                default: q_d = q_q;
            endcase
        end
    end

    // A new forbidden input outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_clr)
            err_d = 1'b0;
        if (illegal)
            err_d = 1'b1;
    end

    // Complement is its own register so q/q_bar change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= 1'b0;
            qb_q  <= 1'b1;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            qb_q  <= ~q_d;
            err_q <= err_d;
        end
    end

    assign q     = q_q;
    assign q_bar = qb_q;
    assign err   = err_q;

endmodule

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH independent clocked flip-flop channels with a shared
// run-time mode (SR, JK, D, T), per-channel enable and sticky error flags
// for the forbidden SR input S=R=1.
// Optional feature: define SR_FF_BANK_ILLEGAL_CNT_EN to add illegal_cnt,
// a saturating count of edges on which any enabled channel saw S=R=1.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   mode         in   2-bit mode select for all channels
//   en           in   WIDTH per-channel update enables
//   a, b         in   WIDTH S/J/D/T and R/K inputs
//   err_clr      in   clears all sticky error bits (and the counter)
//   q, q_bar     out  WIDTH registered state and complement
//   err          out  WIDTH sticky forbidden-input flags
//   illegal_cnt  out  CNT_W forbidden-input event count (macro only)
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ILLEGAL_POL = POL_HOLD,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] err
`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    logic [WIDTH-1:0] illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sr_ff_cell #(
            .ILLEGAL_POL(ILLEGAL_POL)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .mode    (mode),
            .en      (en[i]),
            .a       (a[i]),
            .b       (b[i]),
            .err_clr (err_clr),
            .q       (q[i]),
            .q_bar   (q_bar[i]),
            .err     (err[i]),
            .illegal (illegal[i])
        );
    end

`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
    logic             any_illegal;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign any_illegal = |illegal;

    // Clear first, then increment, so clear+event on one edge yields 1.
    always_comb begin
        cnt_d = err_clr ? '0 : cnt_q;
        if (any_illegal && (cnt_d != '1))
            cnt_d = cnt_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign illegal_cnt = cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg = (^illegal) ^ (CNT_W > 0);
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed-vector bench for sr_ff_bank. Three instances share
// the stimulus and differ only in ILLEGAL_POL (set / hold / reset). With
// SR_FF_BANK_ILLEGAL_CNT_EN defined, counters are checked too, including a
// CNT_W=2 instance for saturation.
module tb_sr_ff_bank;
    import sr_ff_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] en, a, b;
    logic       err_clr;

    logic [3:0] q_s, qb_s, err_s;
    logic [3:0] q_h, qb_h, err_h;
    logic [3:0] q_r, qb_r, err_r;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
    logic [7:0] cnt_s, cnt_h, cnt_r;
    logic [1:0] cnt_sat;
    logic [3:0] q_x, qb_x, err_x;

    sr_ff_bank #(.WIDTH(4), .ILLEGAL_POL(POL_SET), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .q(q_x), .q_bar(qb_x), .err(err_x),
        .illegal_cnt(cnt_sat));
`endif

    sr_ff_bank #(.WIDTH(4), .ILLEGAL_POL(POL_SET), .CNT_W(8)) u_set (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .q(q_s), .q_bar(qb_s), .err(err_s)
`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
        , .illegal_cnt(cnt_s)
`endif
    );

    sr_ff_bank #(.WIDTH(4), .ILLEGAL_POL(POL_HOLD), .CNT_W(8)) u_hold (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .q(q_h), .q_bar(qb_h), .err(err_h)
`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
        , .illegal_cnt(cnt_h)
`endif
    );

    sr_ff_bank #(.WIDTH(4), .ILLEGAL_POL(POL_RST), .CNT_W(8)) u_rst (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .q(q_r), .q_bar(qb_r), .err(err_r)
`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
        , .illegal_cnt(cnt_r)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected q for set/hold/reset-policy instances and the common err.
    task automatic check_all(input string tag, input logic [3:0] es, input logic [3:0] eh,
                             input logic [3:0] er, input logic [3:0] ee);
        check({tag, ".q_set"},   {28'd0, q_s},  {28'd0, es});
        check({tag, ".qb_set"},  {28'd0, qb_s}, {28'd0, ~es});
        check({tag, ".q_hold"},  {28'd0, q_h},  {28'd0, eh});
        check({tag, ".qb_hold"}, {28'd0, qb_h}, {28'd0, ~eh});
        check({tag, ".q_rst"},   {28'd0, q_r},  {28'd0, er});
        check({tag, ".qb_rst"},  {28'd0, qb_r}, {28'd0, ~er});
        check({tag, ".err_set"},  {28'd0, err_s}, {28'd0, ee});
        check({tag, ".err_hold"}, {28'd0, err_h}, {28'd0, ee});
        check({tag, ".err_rst"},  {28'd0, err_r}, {28'd0, ee});
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
        check({tag, ".cnt_set"},  {24'd0, cnt_s}, exp);
        check({tag, ".cnt_hold"}, {24'd0, cnt_h}, exp);
        check({tag, ".cnt_rst"},  {24'd0, cnt_r}, exp);
`else
        if (tag.len() < 0 || exp < 0) $display("unexpected argument");
`endif
    endtask

    task automatic drive(input logic r, input mode_t m, input logic [3:0] e,
                         input logic [3:0] va, input logic [3:0] vb, input logic c);
        @(negedge clk);
        rst = r; mode = m; en = e; a = va; b = vb; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = MODE_SR; en = 4'hF; a = 4'hF; b = 4'hF; err_clr = 1'b0;

        drive(1'b1, MODE_SR, 4'hF, 4'hF, 4'hF, 1'b0);
        drive(1'b1, MODE_SR, 4'hF, 4'hF, 4'hF, 1'b0);
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        check_cnt("reset", 0);

        drive(1'b0, MODE_SR, 4'hF, 4'b0011, 4'b0100, 1'b0);
        check_all("sr_set", 4'b0011, 4'b0011, 4'b0011, 4'h0);
        drive(1'b0, MODE_SR, 4'hF, 4'b0000, 4'b0001, 1'b0);
        check_all("sr_rst", 4'b0010, 4'b0010, 4'b0010, 4'h0);
        drive(1'b0, MODE_SR, 4'hF, 4'b0000, 4'b1111, 1'b0);
        check_all("sr_clr", 4'h0, 4'h0, 4'h0, 4'h0);

        drive(1'b0, MODE_SR, 4'hF, 4'b1000, 4'b1000, 1'b0);
        check_all("sr_forbid0", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        check_cnt("sr_forbid0", 1);
        drive(1'b0, MODE_SR, 4'b0111, 4'b1000, 4'b1000, 1'b0);
        check_all("sr_forbid_dis", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        check_cnt("sr_forbid_dis", 1);

        drive(1'b0, MODE_SR, 4'hF, 4'b1000, 4'b0000, 1'b0);
        check_all("sr_set3", 4'b1000, 4'b1000, 4'b1000, 4'b1000);
        drive(1'b0, MODE_SR, 4'hF, 4'b1000, 4'b1000, 1'b0);
        check_all("sr_forbid1", 4'b1000, 4'b1000, 4'b0000, 4'b1000);
        check_cnt("sr_forbid1", 2);

        drive(1'b0, MODE_SR, 4'hF, 4'b0001, 4'b0001, 1'b1);
        check_all("clr_collide", 4'b1001, 4'b1000, 4'b0000, 4'b0001);
        check_cnt("clr_collide", 1);
        drive(1'b0, MODE_SR, 4'hF, 4'b0000, 4'b0000, 1'b1);
        check_all("err_clr", 4'b1001, 4'b1000, 4'b0000, 4'b0000);
        check_cnt("err_clr", 0);

        drive(1'b0, MODE_D, 4'hF, 4'b0101, 4'b1111, 1'b0);
        check_all("d_load", 4'h5, 4'h5, 4'h5, 4'h0);
        drive(1'b0, MODE_JK, 4'hF, 4'hF, 4'hF, 1'b0);
        check_all("jk_toggle", 4'hA, 4'hA, 4'hA, 4'h0);
        check_cnt("jk_toggle", 0);
        drive(1'b0, MODE_T, 4'hF, 4'h3, 4'hF, 1'b0);
        check_all("t_toggle", 4'h9, 4'h9, 4'h9, 4'h0);
        drive(1'b0, MODE_D, 4'b0011, 4'b0000, 4'b0000, 1'b0);
        check_all("d_partial_en", 4'h8, 4'h8, 4'h8, 4'h0);
        drive(1'b0, MODE_JK, 4'hF, 4'b0110, 4'b1001, 1'b0);
        check_all("jk_setrst", 4'b0110, 4'b0110, 4'b0110, 4'h0);
        drive(1'b0, MODE_JK, 4'hF, 4'b0000, 4'b0000, 1'b0);
        check_all("jk_hold", 4'b0110, 4'b0110, 4'b0110, 4'h0);

        drive(1'b0, MODE_SR, 4'hF, 4'b0100, 4'b0100, 1'b0);
        check_all("sr_forbid2", 4'b0110, 4'b0110, 4'b0010, 4'b0100);
        check_cnt("sr_forbid2", 1);

        drive(1'b1, MODE_T, 4'hF, 4'hF, 4'h0, 1'b0);
        check_all("rst_prio", 4'h0, 4'h0, 4'h0, 4'h0);
        check_cnt("rst_prio", 0);
        drive(1'b0, MODE_T, 4'hF, 4'hF, 4'h0, 1'b0);
        check_all("post_rst", 4'hF, 4'hF, 4'hF, 4'h0);

`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, MODE_SR, 4'hF, 4'b0001, 4'b0001, 1'b0);
            check("sat_cnt2", {30'd0, cnt_sat}, (i < 3) ? i + 1 : 3);
            check("sat_cnt8", {24'd0, cnt_s}, i + 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
